// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// Latency: none, wires only.
// Backpressure: the request is held until the memory acks it (req/ack handshake).
interface fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;

  // Fetch side drives the request and receives the response.
  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  // Memory side sees the request and returns the response.
  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, holds the fetched word until decode consumes it.
// Latency: ack at cycle N -> o_inst_valid at N+1; consume at M -> next o_imem_req at M+1.
// Backpressure: i_stall keeps the held instruction; optional FETCH_MISALIGN_TRAP_EN adds o_misalign trap.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  fetch_unit_if.master imem,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic        o_halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign
`endif
);

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  logic [31:0] redir_tgt;
  logic        redir_bad;
  logic        consume;

  assign imem.o_imem_req  = req_q;
  assign imem.o_imem_addr = pc;

  // Decode fields are straight slices of the held word.
  assign o_opcode = o_inst[6:0];
  assign o_funct3 = o_inst[14:12];
  assign o_funct7 = o_inst[31:25];

  assign consume = o_inst_valid && !i_stall;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned target traps instead of being fetched.
  assign redir_tgt = i_redirect_pc;
  assign redir_bad = |i_redirect_pc[1:0];
`else
  // Without the trap the low bits are simply dropped.
  assign redir_tgt = i_redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  // Fetch FSM: request, hold until consumed, or stop for good on halt/trap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= REQ;
      pc           <= RESET_ADDR;
      req_q        <= 1'b1;
      o_inst       <= 32'h0;
      o_inst_pc    <= 32'h0;
      o_inst_valid <= 1'b0;
      o_halted     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      o_misalign   <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (i_redirect) begin
            // Redirect wins over a same-cycle ack: the returned word is for the old path.
            o_inst_valid <= 1'b0;
            if (redir_bad) begin
              state    <= HALTED;
              req_q    <= 1'b0;
              o_halted <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
              o_misalign <= 1'b1;
`endif
            end else begin
              pc    <= redir_tgt;
              req_q <= 1'b1;
            end
          end else if (imem.i_imem_ack) begin
            o_inst       <= imem.i_imem_rdata;
            o_inst_pc    <= pc;
            o_inst_valid <= 1'b1;
            pc           <= pc + 32'd4;
            req_q        <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (consume && i_halt) begin
            // Halt takes priority over any redirect in the same consume cycle.
            state        <= HALTED;
            req_q        <= 1'b0;
            o_inst_valid <= 1'b0;
            o_halted     <= 1'b1;
          end else if (i_redirect) begin
            o_inst_valid <= 1'b0;
            if (redir_bad) begin
              state    <= HALTED;
              req_q    <= 1'b0;
              o_halted <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
              o_misalign <= 1'b1;
`endif
            end else begin
              pc    <= redir_tgt;
              req_q <= 1'b1;
              state <= REQ;
            end
          end else if (consume) begin
            o_inst_valid <= 1'b0;
            req_q        <= 1'b1;
            state        <= REQ;
          end
        end
        HALTED: begin
          req_q        <= 1'b0;
          o_inst_valid <= 1'b0;
          o_halted     <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park safely rather than fetch garbage.
          state        <= HALTED;
          req_q        <= 1'b0;
          o_inst_valid <= 1'b0;
          o_halted     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 o_imem_req  output  1  instruction memory request, held until acked.
REQ-005 o_imem_addr  output  32  fetch address, stable while o_imem_req=1 and i_imem_ack=0.
REQ-006 i_imem_ack  input  1  memory response valid; meaningful only while o_imem_req=1.
REQ-007 i_imem_rdata  input  32  instruction word, sampled on the ack cycle.
REQ-008 i_stall  input  1  decode/execute not ready to consume the held instruction.
REQ-009 i_redirect  input  1  taken branch/jump; load i_redirect_pc.
REQ-010 i_redirect_pc  input  32  redirect target.
REQ-011 i_halt  input  1  held instruction is a halt (control unit decode).
REQ-012 o_inst  output  32  registered instruction word.
REQ-013 o_inst_pc  output  32  address o_inst was fetched from.
REQ-014 o_inst_valid  output  1  o_inst is valid for consumption.
REQ-015 o_opcode / o_funct3 / o_funct7  output  7/3/7  o_inst[6:0], o_inst[14:12], o_inst[31:25], combinational from o_inst.
REQ-016 o_halted  output  1  fetch permanently stopped.

Function
REQ-017 FSM states SHALL be REQ, HOLD, HALTED; one outstanding request maximum.
REQ-018 REQ: o_imem_req=1, o_imem_addr=pc; on i_imem_ack, o_inst<=i_imem_rdata, o_inst_pc<=pc, o_inst_valid<=1, pc<=pc+4 (mod 2^32 wrap), next HOLD.
REQ-019 HOLD: o_imem_req=0; instruction consumed on a cycle with o_inst_valid=1 and i_stall=0; on consume o_inst_valid<=0, next REQ; while i_stall=1 stay HOLD, o_inst/o_inst_pc/o_inst_valid unchanged.
REQ-020 Redirect (REQ or HOLD, i_redirect=1): pc<=i_redirect_pc, o_inst_valid<=0, next REQ; an ack in the same cycle SHALL be discarded (o_inst not updated).
REQ-021 Redirect in REQ without ack: o_imem_addr SHALL change to new pc on the next cycle only; request counts as abandoned (memory must tolerate).
REQ-022 Halt: consume cycle with i_halt=1 SHALL go HALTED; i_halt has priority over i_redirect in that cycle.
REQ-023 HALTED: o_imem_req=0, o_inst_valid=0, o_halted=1; all inputs ignored until reset.
REQ-024 i_halt and i_redirect SHALL be ignored while o_inst_valid=0 or i_stall=1, except redirect per REQ-020.
REQ-025 Latency: ack at cycle N gives o_inst_valid=1 at N+1; consume at M gives o_imem_req=1 at M+1.

Reset
REQ-026 i_rst=1 SHALL immediately force: pc=RESET_ADDR, state REQ, o_inst=0, o_inst_pc=0, o_inst_valid=0, o_halted=0, o_misalign=0 (if present).
REQ-027 First o_imem_req=1 with o_imem_addr=RESET_ADDR SHALL appear in the first cycle after i_rst deasserts; reset mid-request abandons it.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: adds output o_misalign (1); redirect with i_redirect_pc[1:0]!=0 SHALL set o_misalign=1 and go HALTED, no fetch issued.
REQ-029 Macro undefined: no o_misalign port; redirect target SHALL be used with bits [1:0] forced to 0.

Verification
REQ-030 Reset, RESET_ADDR=0x100, ack 2 cycles after req -> addrs 0x100,0x104,0x108 in order, o_inst_pc matches each.
REQ-031 Hold i_stall=1 for 3 cycles with valid inst 0x00500093 -> o_inst, o_inst_valid stable, o_imem_req=0; release -> req next cycle at pc+4.
REQ-032 i_redirect=1 to 0x200 coincident with ack of 0x104 -> data discarded, next req addr 0x200, o_inst_pc=0x200 on its ack.
REQ-033 Consume cycle with i_halt=1 and i_redirect=1 -> HALTED, o_halted=1, no further req even with ack/redirect pulses.
REQ-034 With FETCH_MISALIGN_TRAP_EN, redirect to 0x202 -> o_misalign=1, o_halted=1; without, next req addr 0x200.
REQ-035 pc=0xFFFF_FFFC ack -> next req addr 0x0000_0000; assert i_rst mid-request -> outputs reset same cycle.
